// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous big-endian byte RAM.
//  - access size encodings presented on the size port
//  - FSM state encodings
//  - nbytes(): number of bytes moved by an access of a given size
package ram_pkg;

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bytes per access; 0 for the illegal encoding.
    function automatic int unsigned nbytes(input logic [1:0] size, input int unsigned data_w);
        case (size)
            SZ_BYTE: nbytes = 1;
            SZ_HALF: nbytes = 2;
            SZ_WORD: nbytes = data_w / 8;
            default: nbytes = 0;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane_steer.sv
// Combinational big-endian lane steering.
//  addr      : byte address of the most-significant byte of the access
//  size      : access size encoding
//  wdata     : right-justified write data
//  rbyte     : array contents at byte_addr[i], one per lane
//  byte_addr : wrapped byte address of lane i (addr + i, modulo 2**ADDR_W)
//  byte_en   : lane i takes part in the access
//  wbyte     : byte written through lane i
//  rdata_c   : right-justified, zero-extended read data assembled from the lanes
module ram_lane_steer
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [7:0]          rbyte     [DATA_W/8],
    output logic [ADDR_W-1:0]   byte_addr [DATA_W/8],
    output logic [DATA_W/8-1:0] byte_en,
    output logic [7:0]          wbyte     [DATA_W/8],
    output logic [DATA_W-1:0]   rdata_c
);

    localparam int unsigned NB = DATA_W / 8;

    int unsigned n_c;

    assign n_c = nbytes(size, DATA_W);

    // Lane 0 carries the most-significant byte; address adds wrap naturally at ADDR_W bits.
    always_comb begin
        rdata_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            byte_addr[i] = addr + ADDR_W'(i);
            byte_en[i]   = (i < n_c);
            wbyte[i]     = '0;
            if (i < n_c) begin
                wbyte[i] = 8'(wdata >> (8 * (n_c - 1 - i)));
                rdata_c  = (rdata_c << 8) | DATA_W'(rbyte[i]);
            end
        end
    end

endmodule

// File: rtl/ram_sync_be.sv
// Synchronous byte-addressed big-endian RAM with request/ready handshake.
//  clk, rst_n : rising-edge clock, asynchronous active-low reset
//  en         : request, held until ready then dropped
//  rw         : 1 read / 0 write, captured at acceptance
//  addr       : byte address of the most-significant byte
//  size       : 00 byte, 01 half, 10 word, 11 illegal
//  dataIn     : right-justified write data, captured at acceptance
//  dataOut    : right-justified read data while returning a read, 'z otherwise
//  ready      : access complete, held until en falls
//  err        : qualifies ready, set for an illegal size
module ram_sync_be
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] dataIn,
    output wire  [DATA_W-1:0] dataOut,
    output logic              ready,
    output logic              err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                cap_load, do_access;

    logic                cap_rw_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [1:0]          cap_size_q;
    logic [DATA_W-1:0]   cap_data_q;

    logic                ready_q, err_q, drive_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [7:0]          mem [DEPTH];

    logic [7:0]          rbyte     [NB];
    logic [ADDR_W-1:0]   byte_addr [NB];
    logic [NB-1:0]       byte_en;
    logic [7:0]          wbyte     [NB];
    logic [DATA_W-1:0]   rdata_c;

    ram_lane_steer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_steer (
        .addr      (cap_addr_q),
        .size      (cap_size_q),
        .wdata     (cap_data_q),
        .rbyte     (rbyte),
        .byte_addr (byte_addr),
        .byte_en   (byte_en),
        .wbyte     (wbyte),
        .rdata_c   (rdata_c)
    );

    // Next state. The counter is loaded at acceptance and the access happens on the
    // edge after it reaches zero, giving WAIT_STATES+1 cycles from acceptance to ready.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        cap_load  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    cap_load = 1'b1;
                    wcnt_d   = WCNT_W'(WAIT_STATES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d   = ST_DONE;
                    do_access = (cap_size_q != SZ_ILL);
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            cap_rw_q   <= 1'b0;
            cap_addr_q <= '0;
            cap_size_q <= '0;
            cap_data_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            drive_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (cap_load) begin
                cap_rw_q   <= rw;
                cap_addr_q <= addr;
                cap_size_q <= size;
                cap_data_q <= dataIn;
            end
            ready_q <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_DONE) && (cap_size_q == SZ_ILL);
            drive_q <= (state_d == ST_DONE) && cap_rw_q && (cap_size_q != SZ_ILL);
            if (do_access && cap_rw_q) rdata_q <= rdata_c;
        end
    end

    // Byte array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (do_access && !cap_rw_q) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i]) mem[byte_addr[i]] <= wbyte[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NB; i++) rbyte[i] = mem[byte_addr[i]];
    end

    assign dataOut = drive_q ? rdata_q : {DATA_W{1'bz}};
    assign ready   = ready_q;
    assign err     = err_q;

endmodule
